// File: rtl/spi_pkg.sv
// Shared frame layout, opcodes, arm-FSM states and the frame checksum
// for the SPI frame unpacker.
package spi_pkg;

    localparam int FRAME_W   = 60;
    localparam int CMD_W     = 52;

    localparam int OP_MSB    = 59;
    localparam int OP_LSB    = 56;
    localparam int ADDR_MSB  = 55;
    localparam int ADDR_LSB  = 48;
    localparam int WDATA_MSB = 47;
    localparam int WDATA_LSB = 16;
    localparam int TAG_MSB   = 15;
    localparam int TAG_LSB   = 8;
    localparam int CHK_MSB   = 7;
    localparam int CHK_LSB   = 0;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_WR  = 4'h1;
    localparam logic [3:0] OP_RD  = 4'h2;

    typedef enum logic {
        WAIT_HIGH = 1'b0,
        ARMED     = 1'b1
    } arm_state_t;

    typedef struct packed {
        logic [3:0]  op;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [7:0]  tag;
    } cmd_t;

    // The opcode nibble is zero-extended so it folds into the byte-wise XOR.
    function automatic logic [7:0] spi_chk(input logic [FRAME_W-1:0] frame);
        return {4'h0, frame[OP_MSB:OP_LSB]}
             ^ frame[ADDR_MSB:ADDR_LSB]
             ^ frame[47:40] ^ frame[39:32] ^ frame[31:24] ^ frame[23:16]
             ^ frame[TAG_MSB:TAG_LSB];
    endfunction

endpackage

// File: rtl/spi_cmd_fifo.sv
// Show-ahead command FIFO; the head entry is visible on dout and reads as
// zero while empty. A pop frees a slot for a push in the same cycle.
module spi_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 52
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/spi_frame_unpacker.sv
// Captures each SPI slave load, validates its checksum, splits it into
// command fields and queues accepted commands on a valid/ready stream.
module spi_frame_unpacker
    import spi_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic                          SPI_CLK,
    input  logic                          reset,
    input  logic                          spi_ldb,
    input  logic [FRAME_W-1:0]            frame_in,
    output logic                          cmd_valid,
    input  logic                          cmd_ready,
    output logic [3:0]                    cmd_op,
    output logic [7:0]                    cmd_addr,
    output logic [31:0]                   cmd_wdata,
    output logic [7:0]                    cmd_tag,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]              chk_err_cnt,
    output logic [CNT_W-1:0]              ovf_cnt
);

    arm_state_t state;
    logic       ldb_q;
    logic       fall;
    logic       frame_good;
    logic       push_req;
    logic       fifo_full;
    logic       fifo_empty;
    logic       overflow;
    cmd_t       push_data;
    cmd_t       head;

    // A strobe already low when reset releases must go high before it can count.
    always_ff @(posedge SPI_CLK) begin
        if (reset) begin
            state <= WAIT_HIGH;
            ldb_q <= 1'b1;
        end else begin
            ldb_q <= spi_ldb;
            if (state == WAIT_HIGH && spi_ldb) begin
                state <= ARMED;
            end
        end
    end

    assign fall       = (state == ARMED) & ldb_q & ~spi_ldb;
    assign frame_good = (spi_chk(frame_in) == frame_in[CHK_MSB:CHK_LSB]);
    assign push_req   = fall & frame_good & (frame_in[OP_MSB:OP_LSB] != OP_NOP);
    assign overflow   = push_req & fifo_full & ~(cmd_valid & cmd_ready);

    assign push_data.op    = frame_in[OP_MSB:OP_LSB];
    assign push_data.addr  = frame_in[ADDR_MSB:ADDR_LSB];
    assign push_data.wdata = frame_in[WDATA_MSB:WDATA_LSB];
    assign push_data.tag   = frame_in[TAG_MSB:TAG_LSB];

    spi_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk   (SPI_CLK),
        .reset (reset),
        .push  (push_req),
        .din   (push_data),
        .pop   (cmd_ready),
        .dout  (head),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign cmd_valid = ~fifo_empty;
    assign cmd_op    = head.op;
    assign cmd_addr  = head.addr;
    assign cmd_wdata = head.wdata;
    assign cmd_tag   = head.tag;

    // Both counters stick at all-ones until reset.
    always_ff @(posedge SPI_CLK) begin
        if (reset) begin
            chk_err_cnt <= '0;
            ovf_cnt     <= '0;
        end else begin
            if (fall && !frame_good && chk_err_cnt != '1) begin
                chk_err_cnt <= chk_err_cnt + CNT_W'(1);
            end
            if (overflow && ovf_cnt != '1) begin
                ovf_cnt <= ovf_cnt + CNT_W'(1);
            end
        end
    end

endmodule
